decode_instruction_queue: RTL
=============================

Name: decode_instruction_queue

Overview:
- Small circular FIFO between the fetch unit and the decode/issue stage.
- Buffers fetched instruction packets (pc, instruction, id, fetch status) so fetch can run ahead of decode stalls.
- Presents the head entry as the decode packet and pops it when decode asserts decode_advance.
- Cleared on gc fetch_flush.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- ID_WIDTH, 3, width of the instruction id field.
- ECODE_WIDTH, 5, width of the fetch error code.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  gc.fetch_flush; discards all entries
- fetch_valid  in  1  fetch offers a packet this cycle
- fetch_ready  out  1  queue accepts a packet this cycle
- fetch_pc  in  32  pc of the offered instruction
- fetch_instruction  in  32  instruction word
- fetch_id  in  ID_WIDTH  id allocated by the id management block
- fetch_ok  in  1  1 = fetch completed without error
- fetch_error_code  in  ECODE_WIDTH  error code, meaningful when fetch_ok=0
- decode_valid  out  1  head entry valid
- decode_pc  out  32  head pc
- decode_instruction  out  32  head instruction
- decode_id  out  ID_WIDTH  head id
- decode_ok  out  1  head fetch status
- decode_error_code  out  ECODE_WIDTH  head error code
- decode_advance  in  1  decode consumes the head this cycle
- almost_full  out  1  count >= DEPTH-1; fetch uses it to stop issuing new requests
- occupancy  out  $clog2(DEPTH)+1  current entry count

Behaviour:
- State: storage array[DEPTH], rd_ptr and wr_ptr ($clog2(DEPTH) bits, wrapping naturally), count ($clog2(DEPTH)+1 bits).
- Reset: rd_ptr=0, wr_ptr=0, count=0. So decode_valid=0, fetch_ready=1, almost_full=0, occupancy=0.
- Storage contents are not reset. Payload outputs are don't-care while decode_valid=0.
- push = fetch_valid & fetch_ready & ~flush.
- pop = decode_advance & decode_valid & ~flush.
- fetch_ready = (count != DEPTH). It does not depend on decode_advance, so there is no combinational path from decode to fetch.
- decode_valid = (count != 0).
- Payload outputs are read combinationally from storage[rd_ptr]. There is no output register.
- Latency: a packet pushed in cycle N is visible at the decode outputs in cycle N+1, with decode_valid=1. No same-cycle bypass.
- On push: storage[wr_ptr] <= packet; wr_ptr <= wr_ptr+1 (mod DEPTH).
- On pop: rd_ptr <= rd_ptr+1 (mod DEPTH).
- count <= count + push - pop. Simultaneous push and pop leaves count unchanged.
- Full (count=DEPTH): fetch_ready=0. A simultaneous pop does not enable a push in the same cycle; the push is accepted the next cycle.
- Empty: decode_advance is ignored and nothing underflows.
- Flush (highest priority, synchronous): rd_ptr=wr_ptr=0, count=0 on the next edge.
  - Any push or pop in the flush cycle is discarded.
  - Outputs hold their pre-flush values during the flush cycle; decode and issue qualify with flush themselves.
  - decode_valid=0 from the following cycle.
- rst and flush asserted together behave like rst.
- Ordering: packets leave in exactly the order they entered; no reordering, no duplication.
- decode_advance is legal only when decode_valid=1. An assertion checks this, and checks count <= DEPTH.

Test Plan:
- Reset, then push pc=0x100/0x104/0x108 on consecutive cycles with decode_advance=0 -> occupancy 1,2,3; almost_full=1 at occupancy 3; head pc stays 0x100.
- Fill to 4 entries -> fetch_ready=0 and a fifth push (pc=0x110) is not accepted. Pop once -> the 0x110 push is accepted the following cycle. Drain order is 0x100,0x104,0x108,0x10C,0x110.
- With the queue at occupancy 2, push and pop in the same cycle -> occupancy stays 2 and the head advances by one entry.
- 10 back-to-back push/pop pairs (pointer wrap) with ids 0..7 repeating -> decode outputs match the pushed sequence exactly, one per cycle, after 1 cycle of initial latency.
- Occupancy 3, flush asserted together with fetch_valid and decode_advance -> next cycle occupancy=0, decode_valid=0. A push of pc=0x200 the cycle after appears at the head with id intact.
- Push a packet with fetch_ok=0, error_code=1, pc=0x300 -> decode_ok=0, decode_error_code=1, decode_pc=0x300 next cycle. Assert rst mid-fill (occupancy 2) -> occupancy=0 and fetch_ready=1 next cycle.

Source files
------------

// File: rtl/decode_instruction_queue_if.sv
// rtl/decode_instruction_queue_if.sv - fetch-to-decode packet channel
interface decode_instruction_queue_if #(
   parameter int ID_WIDTH    = 3,
   parameter int ECODE_WIDTH = 5
);
   logic                   fetch_valid;
   logic                   fetch_ready;
   logic [31:0]            fetch_pc;
   logic [31:0]            fetch_instruction;
   logic [ID_WIDTH-1:0]    fetch_id;
   logic                   fetch_ok;
   logic [ECODE_WIDTH-1:0] fetch_error_code;

   logic                   decode_valid;
   logic [31:0]            decode_pc;
   logic [31:0]            decode_instruction;
   logic [ID_WIDTH-1:0]    decode_id;
   logic                   decode_ok;
   logic [ECODE_WIDTH-1:0] decode_error_code;
   logic                   decode_advance;

   // The queue side: accepts fetch packets, presents the head to decode.
   modport slave (
      input  fetch_valid, fetch_pc, fetch_instruction, fetch_id, fetch_ok,
             fetch_error_code, decode_advance,
      output fetch_ready, decode_valid, decode_pc, decode_instruction,
             decode_id, decode_ok, decode_error_code
   );

   modport master (
      output fetch_valid, fetch_pc, fetch_instruction, fetch_id, fetch_ok,
             fetch_error_code, decode_advance,
      input  fetch_ready, decode_valid, decode_pc, decode_instruction,
             decode_id, decode_ok, decode_error_code
   );
endinterface

// File: rtl/decode_instruction_queue.sv
// rtl/decode_instruction_queue.sv - circular FIFO buffering fetch packets for decode
module decode_instruction_queue #(
   parameter int DEPTH       = 4,
   parameter int ID_WIDTH    = 3,
   parameter int ECODE_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   decode_instruction_queue_if.slave bus,
   output logic                   almost_full,
   output logic [$clog2(DEPTH):0] occupancy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0]            pc;
      logic [31:0]            instruction;
      logic [ID_WIDTH-1:0]    id;
      logic                   ok;
      logic [ECODE_WIDTH-1:0] error_code;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   entry_t        wr_entry;
   entry_t        head;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Ready depends only on our own count, never on decode_advance.
   assign push = bus.fetch_valid & ~full & ~flush;
   assign pop  = bus.decode_advance & ~empty & ~flush;

   assign wr_entry = '{pc:          bus.fetch_pc,
                       instruction: bus.fetch_instruction,
                       id:          bus.fetch_id,
                       ok:          bus.fetch_ok,
                       error_code:  bus.fetch_error_code};

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage is deliberately left unreset; validity comes from count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head = mem_q[rd_ptr_q];

   assign bus.fetch_ready        = ~full;
   assign bus.decode_valid       = ~empty;
   assign bus.decode_pc          = head.pc;
   assign bus.decode_instruction = head.instruction;
   assign bus.decode_id          = head.id;
   assign bus.decode_ok          = head.ok;
   assign bus.decode_error_code  = head.error_code;

   assign almost_full = (count_q >= CW'(DEPTH - 1));
   assign occupancy   = count_q;

   a_advance_needs_valid: assert property (
      @(posedge clk) disable iff (rst) bus.decode_advance |-> !empty);

   a_count_in_range: assert property (
      @(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
endmodule
